// File: rtl/legv8_pkg.sv
// Shared LEGv8 encodings, ALU operation codes and controller state types
// used by the multicycle controller and its decoder.
package legv8_pkg;

  localparam logic [10:0] OPC_ADDS = 11'h558;
  localparam logic [10:0] OPC_SUBS = 11'h758;
  localparam logic [10:0] OPC_AND  = 11'h450;
  localparam logic [10:0] OPC_EOR  = 11'h650;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;
  localparam logic [10:0] OPC_STUR = 11'h7C0;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [7:0]  OPC_BCOND = 8'h54;
  localparam logic [7:0]  OPC_CBZ  = 8'hB4;
  localparam logic [4:0]  COND_LT  = 5'h0B;

  localparam logic [1:0] ALUSRC_REG   = 2'd0;
  localparam logic [1:0] ALUSRC_IMM12 = 2'd1;
  localparam logic [1:0] ALUSRC_IMM9  = 2'd2;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_ORR   = 3'd3,
    ALU_EOR   = 3'd4,
    ALU_PASSB = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_ILLEGAL
  } ctrl_state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LDUR,
    CLS_STUR,
    CLS_B,
    CLS_BLT,
    CLS_CBZ
  } op_class_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational LEGv8 decoder: opcode field and condition code to operation
// class, static datapath controls and an undefined-opcode indication.
module instr_decode
  import legv8_pkg::*;
(
  input  logic [10:0] opc,
  input  logic [4:0]  cond,
  output op_class_e   op_class,
  output logic        sets_flags,
  output logic        reg2loc,
  output logic [1:0]  alu_src,
  output alu_op_e     alu_op,
  output logic        uncond_br,
  output logic        undefined
);

  always_comb begin
    op_class   = CLS_ALU;
    sets_flags = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = ALUSRC_REG;
    alu_op     = ALU_ADD;
    uncond_br  = 1'b0;
    undefined  = 1'b0;
    if (opc[10:1] == OPC_ADDI) begin
      alu_src = ALUSRC_IMM12;
    end else if (opc == OPC_ADDS) begin
      sets_flags = 1'b1;
      reg2loc    = 1'b1;
    end else if (opc == OPC_SUBS) begin
      sets_flags = 1'b1;
      reg2loc    = 1'b1;
      alu_op     = ALU_SUB;
    end else if (opc == OPC_AND) begin
      reg2loc = 1'b1;
      alu_op  = ALU_AND;
    end else if (opc == OPC_EOR) begin
      reg2loc = 1'b1;
      alu_op  = ALU_EOR;
    end else if (opc == OPC_LDUR) begin
      op_class = CLS_LDUR;
      alu_src  = ALUSRC_IMM9;
    end else if (opc == OPC_STUR) begin
      op_class = CLS_STUR;
      alu_src  = ALUSRC_IMM9;
    end else if (opc[10:5] == OPC_B) begin
      op_class  = CLS_B;
      uncond_br = 1'b1;
    end else if (opc[10:3] == OPC_BCOND && cond == COND_LT) begin
      op_class = CLS_BLT;
    end else if (opc[10:3] == OPC_CBZ) begin
      // CBZ tests Rt through the ALU, so the zero flag comes straight from alu_z
      op_class = CLS_CBZ;
      alu_op   = ALU_PASSB;
    end else begin
      undefined = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 controller: sequences fetch/decode/execute/memory/writeback,
// owns IR, NZCV and the retired-instruction counter.
module multicycle_ctrl
  import legv8_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic [31:0]      ir,
  output logic             pc_we,
  output logic             BrTaken,
  output logic             UncondBr,
  output logic             Reg2Loc,
  output logic [1:0]       ALUSrc,
  output logic [2:0]       alu_op,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  ctrl_state_e state, state_next;
  logic        flag_n, flag_z, flag_c, flag_v;
  op_class_e   d_class;
  logic        d_sets_flags, d_reg2loc, d_uncond, d_undef;
  logic [1:0]  d_alu_src;
  alu_op_e     d_alu_op;

  // Z and C are architectural state with no consumer among the supported branches
  logic zc_unused;
  assign zc_unused = flag_z ^ flag_c;

  instr_decode u_decode (
    .opc        (ir[31:21]),
    .cond       (ir[4:0]),
    .op_class   (d_class),
    .sets_flags (d_sets_flags),
    .reg2loc    (d_reg2loc),
    .alu_src    (d_alu_src),
    .alu_op     (d_alu_op),
    .uncond_br  (d_uncond),
    .undefined  (d_undef)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_FETCH;
      ir      <= '0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH && imem_ready) ir <= imem_rdata;
      if (state == ST_EXEC && d_sets_flags) begin
        flag_n <= alu_n;
        flag_z <= alu_z;
        flag_c <= alu_c;
        flag_v <= alu_v;
      end
      if (pc_we) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_we      = 1'b0;
    BrTaken    = 1'b0;
    UncondBr   = 1'b0;
    Reg2Loc    = 1'b0;
    ALUSrc     = ALUSRC_REG;
    alu_op     = ALU_ADD;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    illegal    = 1'b0;
    if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
      Reg2Loc  = d_reg2loc;
      ALUSrc   = d_alu_src;
      alu_op   = d_alu_op;
      UncondBr = d_uncond;
    end
    case (state)
      ST_FETCH: begin
        // reset holds state at FETCH, so the request is gated to stay low in reset
        imem_req = reset_n;
        if (imem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: state_next = d_undef ? ST_ILLEGAL : ST_EXEC;
      ST_EXEC: begin
        case (d_class)
          CLS_B: begin
            pc_we      = 1'b1;
            BrTaken    = 1'b1;
            state_next = ST_FETCH;
          end
          CLS_BLT: begin
            pc_we      = 1'b1;
            BrTaken    = flag_n ^ flag_v;
            state_next = ST_FETCH;
          end
          CLS_CBZ: begin
            pc_we      = 1'b1;
            BrTaken    = alu_z;
            state_next = ST_FETCH;
          end
          CLS_LDUR, CLS_STUR: state_next = ST_MEM;
          default: state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (d_class == CLS_STUR);
        if (dmem_ready) begin
          if (d_class == CLS_STUR) begin
            pc_we      = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        RegWrite   = 1'b1;
        MemToReg   = (d_class == CLS_LDUR);
        pc_we      = 1'b1;
        state_next = ST_FETCH;
      end
      ST_ILLEGAL: illegal = 1'b1;
      default: state_next = ST_FETCH;
    endcase
  end

endmodule
